// File: rtl/pipe_hazard_regs.sv
// -----------------------------------------------------------------------------
// pipe_hazard_regs
//
// Carries the register-number and control fields of each instruction through
// the ID/EX -> EX/MEM -> MEM/WB pipeline registers. It feeds the forwarding
// unit and detects load-use hazards. On a hazard it raises Stall, which holds
// PC and IF/ID for one cycle, and it puts a bubble into ID/EX. A taken branch
// (Branch_Flush) also turns ID/EX into a bubble, and it overrides the stall,
// because the instruction sitting in ID is being killed.
//
// Ports
//   clk              pipeline clock; all state changes on the rising edge
//   reset            synchronous, active-low; clears every register
//   IF_ID_RS/RT      source register fields of the instruction in ID
//   ID_RD            destination register chosen in ID
//   ID_RegWrite      the ID instruction writes the register file
//   ID_MemRead       the ID instruction is a load
//   ID_UsesRT        the ID instruction reads rt
//   Branch_Flush     a taken branch resolved in EX; kill IF and ID
//   ID_EX_*          ID/EX fields (RS, RT, RD, RegWrite, MemRead)
//   EX_MEM_*         EX/MEM fields (RD, RegWrite, MemRead)
//   MEM_WB_*         MEM/WB fields (RD, RegWrite)
//   Stall            combinational; hold PC and IF/ID this cycle
//   Stall_Count      saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module pipe_hazard_regs #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RS,
    input  logic [4:0]       IF_ID_RT,
    input  logic [4:0]       ID_RD,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_UsesRT,
    input  logic             Branch_Flush,
    output logic [4:0]       ID_EX_RS,
    output logic [4:0]       ID_EX_RT,
    output logic [4:0]       ID_EX_RD,
    output logic             ID_EX_RegWrite,
    output logic             ID_EX_MemRead,
    output logic [4:0]       EX_MEM_RD,
    output logic             EX_MEM_RegWrite,
    output logic             EX_MEM_MemRead,
    output logic [4:0]       MEM_WB_RD,
    output logic             MEM_WB_RegWrite,
    output logic             Stall,
    output logic [CNT_W-1:0] Stall_Count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [4:0]       id_ex_rs_r;
    logic [4:0]       id_ex_rt_r;
    logic [4:0]       id_ex_rd_r;
    logic             id_ex_regwrite_r;
    logic             id_ex_memread_r;
    logic [4:0]       ex_mem_rd_r;
    logic             ex_mem_regwrite_r;
    logic             ex_mem_memread_r;
    logic [4:0]       mem_wb_rd_r;
    logic             mem_wb_regwrite_r;
    logic [CNT_W-1:0] stall_count_r;

    logic             rs_match_s;
    logic             rt_match_s;
    logic             hazard_s;
    logic             stall_s;
    logic             bubble_s;

    // Load-use detection against the load now in ID/EX; a destination of $0 is never a dependency.
    always_comb begin
        rs_match_s = 1'b0;
        rt_match_s = 1'b0;
        hazard_s   = 1'b0;
        if (id_ex_memread_r && (id_ex_rd_r != 5'd0)) begin
            rs_match_s = (id_ex_rd_r == IF_ID_RS);
            rt_match_s = ID_UsesRT && (id_ex_rd_r == IF_ID_RT);
            hazard_s   = rs_match_s || rt_match_s;
        end else begin
            hazard_s   = 1'b0;
        end
    end

    // The flush wins over the stall: an instruction that is being killed must not hold the front end.
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        if (Branch_Flush) begin
            stall_s  = 1'b0;
            bubble_s = 1'b1;
        end else begin
            stall_s  = hazard_s;
            bubble_s = hazard_s;
        end
    end

    // Pipeline registers; only ID/EX sees bubbles, the older stages always advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_ex_rs_r        <= 5'd0;
            id_ex_rt_r        <= 5'd0;
            id_ex_rd_r        <= 5'd0;
            id_ex_regwrite_r  <= 1'b0;
            id_ex_memread_r   <= 1'b0;
            ex_mem_rd_r       <= 5'd0;
            ex_mem_regwrite_r <= 1'b0;
            ex_mem_memread_r  <= 1'b0;
            mem_wb_rd_r       <= 5'd0;
            mem_wb_regwrite_r <= 1'b0;
        end else begin
            if (bubble_s) begin
                id_ex_rs_r       <= 5'd0;
                id_ex_rt_r       <= 5'd0;
                id_ex_rd_r       <= 5'd0;
                id_ex_regwrite_r <= 1'b0;
                id_ex_memread_r  <= 1'b0;
            end else begin
                id_ex_rs_r       <= IF_ID_RS;
                id_ex_rt_r       <= IF_ID_RT;
                id_ex_rd_r       <= ID_RD;
                id_ex_regwrite_r <= ID_RegWrite;
                id_ex_memread_r  <= ID_MemRead;
            end
            ex_mem_rd_r       <= id_ex_rd_r;
            ex_mem_regwrite_r <= id_ex_regwrite_r;
            ex_mem_memread_r  <= id_ex_memread_r;
            mem_wb_rd_r       <= ex_mem_rd_r;
            mem_wb_regwrite_r <= ex_mem_regwrite_r;
        end
    end

    // Stall cycle counter; it holds at all-ones instead of wrapping so a long run never reads as small.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign ID_EX_RS        = id_ex_rs_r;
    assign ID_EX_RT        = id_ex_rt_r;
    assign ID_EX_RD        = id_ex_rd_r;
    assign ID_EX_RegWrite  = id_ex_regwrite_r;
    assign ID_EX_MemRead   = id_ex_memread_r;
    assign EX_MEM_RD       = ex_mem_rd_r;
    assign EX_MEM_RegWrite = ex_mem_regwrite_r;
    assign EX_MEM_MemRead  = ex_mem_memread_r;
    assign MEM_WB_RD       = mem_wb_rd_r;
    assign MEM_WB_RegWrite = mem_wb_regwrite_r;
    assign Stall           = stall_s;
    assign Stall_Count     = stall_count_r;

endmodule
